// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - IR fields, memory/ALU status and datapath controls of the multicycle core
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic [1:0] imm_src;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr, state_dbg
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal_instr, state_dbg
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;

  state_t     state, state_next;
  logic       is_rtype;
  logic       f3_bad;
  logic [3:0] alu_fn;
  logic       pcw, mw, irw, rw, ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= state_t'(RESET_STATE);
    else        state <= state_next;
  end

  // SUB is only reachable from R-type; I-type 000 is always addi.
  always_comb begin
    is_rtype = (bus.opcode == OP_R);
    f3_bad   = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b101);
    case (bus.funct3)
      3'b000:  alu_fn = (is_rtype && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b100:  alu_fn = ALU_XOR;
      3'b110:  alu_fn = ALU_OR;
      3'b111:  alu_fn = ALU_AND;
      default: alu_fn = ALU_ADD;
    endcase
  end

  always_comb begin
    state_next     = FETCH;
    pcw            = 1'b0;
    mw             = 1'b0;
    irw            = 1'b0;
    rw             = 1'b0;
    ill            = 1'b0;
    bus.adr_src    = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_ctrl   = ALU_ADD;
    bus.imm_src    = 2'b00;
    case (state)
      FETCH: begin
        bus.alu_src_b  = 2'b10;
        bus.result_src = 2'b10;
        irw            = bus.mem_ready;
        pcw            = bus.mem_ready;
        state_next     = bus.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b01;
        case (bus.opcode)
          OP_SW:   bus.imm_src = 2'b01;
          OP_BEQ:  bus.imm_src = 2'b10;
          OP_JAL:  bus.imm_src = 2'b11;
          default: bus.imm_src = 2'b00;
        endcase
        ill = 1'b1;
        case (bus.opcode)
          OP_LW, OP_SW: begin state_next = MEMADR; ill = 1'b0; end
          OP_R:   if (!f3_bad) begin state_next = EXECUTER; ill = 1'b0; end
          OP_I:   if (!f3_bad) begin state_next = EXECUTEI; ill = 1'b0; end
          OP_BEQ: if (bus.funct3 == 3'b000) begin state_next = BEQ; ill = 1'b0; end
          OP_JAL: begin state_next = JAL; ill = 1'b0; end
          default: ;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.imm_src   = (bus.opcode == OP_SW) ? 2'b01 : 2'b00;
        state_next    = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        state_next  = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.result_src = 2'b01;
        rw             = 1'b1;
      end
      MEMWRITE: begin
        bus.adr_src = 1'b1;
        mw          = 1'b1;
        state_next  = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        bus.alu_src_a = 2'b10;
        bus.alu_ctrl  = alu_fn;
        state_next    = ALUWB;
      end
      EXECUTEI: begin
        bus.alu_src_a = 2'b10;
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = alu_fn;
        state_next    = ALUWB;
      end
      ALUWB: rw = 1'b1;
      BEQ: begin
        bus.alu_src_a = 2'b10;
        bus.alu_ctrl  = ALU_SUB;
        pcw           = bus.zero;
      end
      JAL: begin
        bus.alu_src_a = 2'b01;
        bus.alu_src_b = 2'b10;
        pcw           = 1'b1;
        state_next    = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is asserted.
  assign bus.pc_write      = pcw & rst_n;
  assign bus.mem_write     = mw  & rst_n;
  assign bus.ir_write      = irw & rst_n;
  assign bus.reg_write     = rw  & rst_n;
  assign bus.illegal_instr = ill & rst_n;
  assign bus.state_dbg     = state;

endmodule
